// File: rtl/unibus_blkdma.sv
// Unibus block-DMA master: moves 1..DEPTH words between a local buffer and consecutive
// Unibus addresses under ARM register control, with NPR arbitration, deskew and SSYN timeout.
module unibus_blkdma #(
    parameter int DEPTH   = 16,
    parameter int MAXBRST = 4,
    parameter int DESKEW  = 15,
    parameter int TOUT    = 1023,
    parameter int GLITCH  = 4
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        halted_in,
    input  logic        init_in_h,
    input  logic        npg_in_l,
    input  logic        ssyn_in_h,
    input  logic [15:0] d_in_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h,
    output logic        bbsy_out_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    output logic        npg_out_l
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ADDR, S_DSK1, S_WSSYN, S_DSK2, S_DSK3, S_END
    } state_t;

    state_t        state;
    logic          fail, dato, msyn_q;
    logic [15:0]   count, timer;
    logic [17:0]   addr;
    logic [AW-1:0] bufptr, idx;
    logic [7:0]    glcnt, burst;
    logic [15:0]   mem [DEPTH];

    logic          busy, wr_csr, abort_wr, kill, start_ok, dsk_done;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [15:0]   mem_wd;
    logic          unused_wdata;

    assign busy         = (state != S_IDLE);
    assign wr_csr       = armwrite && (armwaddr == 3'd1);
    assign abort_wr     = wr_csr && armwdata[29];
    assign kill         = busy && (abort_wr || init_in_h);
    assign start_ok     = (armwdata[15:0] != 16'd0) && (armwdata[15:0] <= 16'(DEPTH));
    assign dsk_done     = (timer == 16'(DESKEW - 1));
    assign unused_wdata = ^{armwdata[31:30], armwdata[26:18]};

    // MSYN must fall in the very cycle an abort or INIT arrives, so it is gated here.
    assign msyn_out_h = msyn_q && !kill;
    assign npg_out_l  = npr_out_h ? 1'b1 : npg_in_l;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bufptr;
        mem_wd = armwdata[15:0];
        if (state == S_DSK2 && dsk_done && !dato && !kill) begin
            mem_we = 1'b1;
            mem_wa = idx;
            mem_wd = d_in_h;
        end else if (!busy && armwrite && armwaddr == 3'd4) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: the buffer has no reset; its contents survive RESET_N and it can map onto RAM.
    always_ff @(posedge CLOCK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_comb begin
        armrdata = 32'hDEADBEEF;
        case (armraddr)
            3'd0: armrdata = {16'h4244, 4'h2, 12'h001};
            3'd1: armrdata = {busy, fail, 2'b00, dato, 11'd0, count};
            3'd2: armrdata = {14'd0, addr};
            3'd3: armrdata = {{(32-AW){1'b0}}, bufptr};
            3'd4: armrdata = {16'd0, mem[bufptr]};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;  fail <= 1'b0;  dato <= 1'b0;  count <= '0;  addr <= '0;
            bufptr <= '0;  idx <= '0;  timer <= '0;  glcnt <= '0;  burst <= '0;  msyn_q <= 1'b0;
            a_out_h <= '0;  c_out_h <= '0;  d_out_h <= '0;
            bbsy_out_h <= 1'b0;  npr_out_h <= 1'b0;  sack_out_h <= 1'b0;
        end else if (kill) begin
            state <= S_IDLE;  fail <= !init_in_h;  msyn_q <= 1'b0;
            a_out_h <= '0;  c_out_h <= '0;  d_out_h <= '0;
            bbsy_out_h <= 1'b0;  npr_out_h <= 1'b0;  sack_out_h <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (armwrite) begin
                    case (armwaddr)
                        3'd1: begin
                            dato  <= armwdata[27];
                            count <= armwdata[15:0];
                            if (armwdata[28]) begin
                                if (start_ok) begin
                                    fail <= 1'b0;  idx <= '0;  glcnt <= '0;  burst <= '0;
                                    state <= S_REQ;
                                end else begin
                                    fail <= 1'b1;
                                end
                            end
                        end
                        3'd2: addr   <= armwdata[17:0];
                        3'd3: bufptr <= armwdata[AW-1:0];
                        3'd4: bufptr <= bufptr + AW'(1);
                        default: ;
                    endcase
                end
                S_REQ: begin
                    if (halted_in || (npr_out_h && !npg_in_l && glcnt == 8'(GLITCH - 1))) begin
                        npr_out_h <= 1'b0;  bbsy_out_h <= 1'b1;  sack_out_h <= 1'b1;
                        glcnt <= '0;  state <= S_ADDR;
                    end else begin
                        // Never raise NPR while a grant is passing through to a device downstream.
                        if (npg_in_l) npr_out_h <= 1'b1;
                        glcnt <= (npr_out_h && !npg_in_l) ? glcnt + 8'd1 : 8'd0;
                    end
                end
                S_ADDR: begin
                    a_out_h <= addr;
                    c_out_h <= dato ? 2'b10 : 2'b00;
                    d_out_h <= dato ? mem[idx] : 16'h0000;
                    timer   <= '0;
                    state   <= S_DSK1;
                end
                S_DSK1: if (dsk_done) begin
                    timer <= '0;  msyn_q <= 1'b1;  state <= S_WSSYN;
                end else timer <= timer + 16'd1;
                S_WSSYN: if (ssyn_in_h) begin
                    timer <= '0;  state <= S_DSK2;
                end else if (timer == 16'(TOUT - 1)) begin
                    fail <= 1'b1;  msyn_q <= 1'b0;  state <= S_END;
                end else timer <= timer + 16'd1;
                S_DSK2: if (dsk_done) begin
                    timer <= '0;  msyn_q <= 1'b0;  state <= S_DSK3;
                end else timer <= timer + 16'd1;
                S_DSK3: if (dsk_done) begin
                    timer <= '0;
                    addr  <= addr + 18'd2;
                    count <= count - 16'd1;
                    idx   <= idx + AW'(1);
                    if (count == 16'd1) begin
                        state <= S_END;
                    end else if (burst == 8'(MAXBRST - 1)) begin
                        burst <= '0;
                        a_out_h <= '0;  c_out_h <= '0;  d_out_h <= '0;
                        bbsy_out_h <= 1'b0;  sack_out_h <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        burst <= burst + 8'd1;
                        state <= S_ADDR;
                    end
                end else timer <= timer + 16'd1;
                S_END: begin
                    a_out_h <= '0;  c_out_h <= '0;  d_out_h <= '0;  msyn_q <= 1'b0;
                    bbsy_out_h <= 1'b0;  sack_out_h <= 1'b0;  npr_out_h <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unibus_blkdma.sv
// Bench for unibus_blkdma: ARM driver, Unibus slave memory and NPR arbiter models, with a
// scoreboard of expected bus cycles checked by an independent monitor.
module tb_unibus_blkdma;
    localparam int DEPTH = 16, MAXBRST = 4, DESKEW = 15, TOUT = 1023, GLITCH = 4;
    localparam logic [17:0] AMASK = 18'h3FFFF;

    logic        CLOCK = 1'b0, RESET_N = 1'b0;
    logic        armwrite = 1'b0;
    logic [2:0]  armraddr = 3'd0, armwaddr = 3'd0;
    logic [31:0] armwdata = 32'd0, armrdata;
    logic        halted_in = 1'b0, init_in_h = 1'b0, npg_in_l = 1'b1, ssyn_in_h = 1'b0;
    logic [15:0] d_in_h = 16'd0;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h, bbsy_out_h, npr_out_h, sack_out_h, npg_out_l;

    unibus_blkdma #(.DEPTH(DEPTH), .MAXBRST(MAXBRST), .DESKEW(DESKEW), .TOUT(TOUT), .GLITCH(GLITCH)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .armwrite(armwrite), .armraddr(armraddr),
        .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata), .halted_in(halted_in),
        .init_in_h(init_in_h), .npg_in_l(npg_in_l), .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h),
        .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h), .msyn_out_h(msyn_out_h),
        .bbsy_out_h(bbsy_out_h), .npr_out_h(npr_out_h), .sack_out_h(sack_out_h), .npg_out_l(npg_out_l));

    always #5 CLOCK = ~CLOCK;

    typedef struct packed { logic [17:0] a; logic [1:0] c; logic [15:0] d; } cyc_t;

    int          n_checks = 0, n_pass = 0;
    cyc_t        exp_q[$];
    logic [15:0] umem [logic [17:0]];
    logic [15:0] bmodel [DEPTH];
    bit          slave_on = 1'b1, auto_grant = 1'b1;
    int          bbsy_rises = 0, npr_rises = 0, proto_err = 0;
    logic        pm = 1'b0, pb = 1'b0, pn = 1'b0;
    cyc_t        got, want;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] umem_rd(input logic [17:0] a);
        return umem.exists(a) ? umem[a] : 16'h0000;
    endfunction

    // Monitor: each MSYN rise pops one expected bus cycle; also tracks tenures and protocol rules.
    initial forever begin
        @(negedge CLOCK);
        if (msyn_out_h && !pm) begin
            check("bus_cycle_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = '{a: a_out_h, c: c_out_h, d: d_out_h};
                check("bus_cycle_a_c_d", 64'(got), 64'(want));
            end
        end
        if (bbsy_out_h && !pb) bbsy_rises++;
        if (npr_out_h && !pn) npr_rises++;
        if (npr_out_h && (bbsy_out_h || !npg_out_l)) proto_err++;
        if (msyn_out_h && !bbsy_out_h) proto_err++;
        pm = msyn_out_h;  pb = bbsy_out_h;  pn = npr_out_h;
    end

    // Unibus slave: random response delay, stores DATO data, returns memory data on DATI.
    initial forever begin
        @(negedge CLOCK);
        if (slave_on && RESET_N && msyn_out_h) begin
            repeat ($urandom_range(0, 3)) @(negedge CLOCK);
            if (msyn_out_h) begin
                if (c_out_h == 2'b10) umem[a_out_h] = d_out_h;
                else d_in_h = umem_rd(a_out_h);
                ssyn_in_h = 1'b1;
                for (int k = 0; k < 200 && msyn_out_h; k++) @(negedge CLOCK);
                ssyn_in_h = 1'b0;
                d_in_h = 16'h0000;
            end
        end
    end

    // Upstream arbiter: grants NPR after a random delay, withdraws the grant once SACK is seen.
    initial forever begin
        @(negedge CLOCK);
        if (auto_grant && RESET_N && npr_out_h) begin
            repeat ($urandom_range(0, 3)) @(negedge CLOCK);
            npg_in_l = 1'b0;
            for (int k = 0; k < 50 && !sack_out_h; k++) @(negedge CLOCK);
            npg_in_l = 1'b1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge CLOCK); #1;
        armwrite = 1'b1;  armwaddr = a;  armwdata = d;
        @(posedge CLOCK); #1;
        armwrite = 1'b0;
    endtask

    task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge CLOCK); #1;
        armraddr = a;
        #1 d = armrdata;
    endtask

    task automatic wait_msyn(input int budget, input string name);
        for (int k = 0; k < budget && !msyn_out_h; k++) @(negedge CLOCK);
        check(name, 64'(msyn_out_h), 64'd1);
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        logic [31:0] r;
        cyc = 0;
        arm_rd(3'd1, r);
        while (r[31] && cyc < budget) begin
            arm_rd(3'd1, r);
            cyc++;
        end
        check("busy_clears_in_budget", 64'(r[31]), 64'd0);
    endtask

    function automatic logic [17:0] word_addr(input logic [17:0] base, input int i);
        return (base + 18'(2 * i)) & AMASK;
    endfunction

    // Loads the DUT buffer for DATO, prepares slave memory for DATI, queues the expected cycles.
    task automatic start_xfer(input bit dato, input logic [17:0] base, input int cnt);
        cyc_t e;
        if (dato) begin
            arm_wr(3'd3, 32'd0);
            for (int i = 0; i < DEPTH; i++) arm_wr(3'd4, {16'd0, bmodel[i]});
        end
        for (int i = 0; i < cnt; i++) begin
            e.a = word_addr(base, i);
            if (!dato) begin
                umem[e.a] = 16'($urandom);
                bmodel[i] = umem[e.a];
            end
            e.c = dato ? 2'b10 : 2'b00;
            e.d = dato ? bmodel[i] : 16'h0000;
            exp_q.push_back(e);
        end
        arm_wr(3'd2, {14'd0, base});
        bbsy_rises = 0;
        npr_rises  = 0;
        arm_wr(3'd1, (32'(dato) << 27) | 32'h1000_0000 | 32'(cnt));
    endtask

    task automatic finish_xfer(input bit dato, input logic [17:0] base, input int cnt, input bit halted);
        int cyc;
        logic [31:0] r;
        wait_idle(200 * cnt + 500, cyc);
        arm_rd(3'd1, r);
        check("xfer_csr_done", 64'(r), 64'({4'b0000, dato, 11'd0, 16'd0}));
        arm_rd(3'd2, r);
        check("xfer_final_addr", 64'(r), 64'(word_addr(base, cnt)));
        check("xfer_all_cycles_seen", 64'(exp_q.size()), 64'd0);
        check("xfer_grant_tenures", 64'(bbsy_rises), 64'((cnt + MAXBRST - 1) / MAXBRST));
        if (halted) check("xfer_halted_no_npr", 64'(npr_rises), 64'd0);
        for (int i = 0; i < cnt; i++) begin
            if (dato) begin
                check("dato_slave_mem", 64'(umem_rd(word_addr(base, i))), 64'(bmodel[i]));
            end else begin
                arm_wr(3'd3, 32'(i));
                arm_rd(3'd4, r);
                check("dati_buffer", 64'(r), 64'(bmodel[i]));
            end
        end
    endtask

    task automatic run_xfer(input bit dato, input logic [17:0] base, input int cnt, input bit halted, input bit poke);
        halted_in = halted;
        start_xfer(dato, base, cnt);
        if (poke) begin
            wait_msyn(400, "poke_wait_msyn");
            arm_wr(3'd2, 32'h0002_AAAA);
            arm_wr(3'd1, 32'h1000_0005);
        end
        finish_xfer(dato, base, cnt, halted);
        halted_in = 1'b0;
    endtask

    task automatic bus_quiet(input string name);
        check(name, 64'({a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h, npr_out_h, sack_out_h}), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        int          cyc;
        bit          dd;
        int          cnt;
        logic [17:0] ad;

        // Reset state
        repeat (3) @(negedge CLOCK);
        bus_quiet("reset_bus_outputs");
        check("reset_npg_passthrough_1", 64'(npg_out_l), 64'd1);
        npg_in_l = 1'b0;
        #1 check("reset_npg_passthrough_0", 64'(npg_out_l), 64'd0);
        npg_in_l = 1'b1;
        @(negedge CLOCK) RESET_N = 1'b1;
        arm_rd(3'd0, r);  check("reg_id", 64'(r), 64'h4244_2001);
        arm_rd(3'd1, r);  check("reset_csr", 64'(r), 64'd0);
        arm_rd(3'd2, r);  check("reset_addr", 64'(r), 64'd0);
        arm_rd(3'd3, r);  check("reset_bufptr", 64'(r), 64'd0);
        arm_rd(3'd5, r);  check("unmapped_reg5", 64'(r), 64'hDEAD_BEEF);

        // DATO 1,2,3 at 001000 with the processor halted
        for (int i = 0; i < DEPTH; i++) bmodel[i] = 16'($urandom);
        bmodel[0] = 16'd1;  bmodel[1] = 16'd2;  bmodel[2] = 16'd3;
        run_xfer(1'b1, 18'o001000, 3, 1'b1, 1'b0);

        // DATI 8 words through NPR arbitration: two tenures of MAXBRST
        run_xfer(1'b0, 18'o004000, 8, 1'b0, 1'b0);

        // Address wrap 777776 -> 000000
        for (int i = 0; i < DEPTH; i++) bmodel[i] = 16'($urandom);
        run_xfer(1'b1, 18'o777776, 2, 1'b1, 1'b0);

        // NPG glitch filter
        auto_grant = 1'b0;
        start_xfer(1'b0, 18'o010000, 2);
        for (int k = 0; k < 20 && !npr_out_h; k++) @(negedge CLOCK);
        check("glitch_npr_raised", 64'(npr_out_h), 64'd1);
        npg_in_l = 1'b0;
        repeat (2) @(negedge CLOCK);
        npg_in_l = 1'b1;
        repeat (6) @(negedge CLOCK);
        check("glitch_short_no_bbsy", 64'({bbsy_out_h, npr_out_h}), 64'b01);
        npg_in_l = 1'b0;
        repeat (GLITCH + 2) @(negedge CLOCK);
        check("glitch_held_takes_bus", 64'({bbsy_out_h, npr_out_h, sack_out_h}), 64'b101);
        npg_in_l = 1'b1;
        auto_grant = 1'b1;
        finish_xfer(1'b0, 18'o010000, 2, 1'b0);

        // SSYN timeout: no responder
        slave_on = 1'b0;
        halted_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) bmodel[i] = 16'($urandom);
        start_xfer(1'b1, 18'o020000, 3);
        wait_msyn(200, "timeout_msyn_rises");
        wait_idle(3000, cyc);
        check("timeout_latency_window", 64'(cyc >= TOUT - 2 && cyc <= TOUT + 10), 64'd1);
        bus_quiet("timeout_bus_released");
        arm_rd(3'd1, r);  check("timeout_csr", 64'(r), 64'h4800_0003);
        arm_rd(3'd2, r);  check("timeout_addr_unchanged", 64'(r), 64'(18'o020000));
        check("timeout_pending_cycles", 64'(exp_q.size()), 64'd2);
        exp_q.delete();

        // Abort while waiting for SSYN
        start_xfer(1'b1, 18'o030000, 4);
        wait_msyn(200, "abort_msyn_rises");
        @(posedge CLOCK); #1;
        armwrite = 1'b1;  armwaddr = 3'd1;  armwdata = 32'h2000_0000;
        #1 check("abort_msyn_same_cycle", 64'(msyn_out_h), 64'd0);
        @(posedge CLOCK); #1;
        armwrite = 1'b0;
        bus_quiet("abort_bus_next_cycle");
        arm_rd(3'd1, r);  check("abort_csr", 64'(r), 64'h4800_0004);
        exp_q.delete();

        // INIT mid-cycle: aborts without flagging failure
        start_xfer(1'b0, 18'o040000, 1);
        wait_msyn(200, "init_msyn_rises");
        @(posedge CLOCK); #1;
        init_in_h = 1'b1;
        #1 check("init_msyn_same_cycle", 64'(msyn_out_h), 64'd0);
        @(posedge CLOCK); #1;
        init_in_h = 1'b0;
        bus_quiet("init_bus_next_cycle");
        arm_rd(3'd1, r);  check("init_csr", 64'(r), 64'h0000_0001);
        exp_q.delete();
        slave_on = 1'b1;
        halted_in = 1'b0;

        // Start with count 0: fail only, no bus activity
        bbsy_rises = 0;  npr_rises = 0;
        arm_wr(3'd1, 32'h1000_0000);
        repeat (10) @(negedge CLOCK);
        arm_rd(3'd1, r);  check("count0_csr_fail", 64'(r), 64'h4000_0000);
        check("count0_no_bus", 64'(bbsy_rises + npr_rises), 64'd0);

        // Random transfers; one pokes registers while busy, which must be ignored
        for (int t = 0; t < 4; t++) begin
            dd  = 1'($urandom_range(0, 1));
            cnt = $urandom_range(1, DEPTH);
            ad  = 18'($urandom) & 18'h3FFFE;
            for (int i = 0; i < DEPTH; i++) bmodel[i] = 16'($urandom);
            run_xfer(dd, ad, cnt, 1'($urandom_range(0, 1)), t == 1);
        end

        // Abort while idle changes nothing; count above DEPTH fails
        arm_wr(3'd1, 32'h2000_0000);
        arm_rd(3'd1, r);  check("abort_idle_no_effect", 64'(r), 64'h0000_0000);
        arm_wr(3'd1, 32'h1000_0000 | 32'(DEPTH + 1));
        arm_rd(3'd1, r);  check("count_over_depth_fail", 64'(r), 64'(32'h4000_0000 | 32'(DEPTH + 1)));

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < DEPTH; i++) bmodel[i] = 16'($urandom);
        start_xfer(1'b1, 18'o050000, 8);
        wait_msyn(400, "reset_burst_msyn_rises");
        @(posedge CLOCK); #3;
        RESET_N = 1'b0;
        #1 bus_quiet("async_reset_bus_outputs");
        check("async_reset_npg_passthrough", 64'(npg_out_l), 64'(npg_in_l));
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        arm_rd(3'd1, r);  check("async_reset_csr", 64'(r), 64'd0);
        arm_rd(3'd2, r);  check("async_reset_addr", 64'(r), 64'd0);
        exp_q.delete();

        check("protocol_violations", 64'(proto_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
